// File: rtl/wc_winograd_f44_pkg.sv
// wc_pkg: shared widths, default taps and sample/accumulator types for the Winograd F(4,4) tile
package wc_pkg;
    localparam int DW_DEF = 10;
    localparam int N_IN   = 7;
    localparam int N_OUT  = 4;
    localparam int N_TAP  = 4;
    localparam int G0_DEF = 1;
    localparam int G1_DEF = -2;
    localparam int G2_DEF = 3;
    localparam int G3_DEF = 1;
    typedef logic signed [DW_DEF-1:0]   sample_t;
    typedef logic signed [2*DW_DEF+3:0] acc_t;
endpackage

// File: rtl/wc_winograd_f44_if.sv
// wc_winograd_f44_if: sample tile in, correlation results out
interface wc_winograd_f44_if #(parameter int DW = 10) ();
    logic [7*DW-1:0] D;
    logic [4*DW-1:0] Z;
    modport master (output D, input Z);
    modport slave  (input D, output Z);
endinterface

// File: rtl/wc_winograd_f44_f22.sv
// wc_f22: F(2,2) kernel products; the caller adds m0+m1 and m1+m2 to form the two outputs
module wc_f22 #(
    parameter int W  = 24,
    parameter int GA = 1,
    parameter int GB = -2
) (
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] x2,
    output logic signed [W-1:0] m0,
    output logic signed [W-1:0] m1,
    output logic signed [W-1:0] m2
);
    localparam logic signed [W-1:0] KA = W'(GA);
    localparam logic signed [W-1:0] KS = W'(GA + GB);
    localparam logic signed [W-1:0] KB = W'(GB);
    assign m0 = (x0 - x1) * KA;
    assign m1 = x1 * KS;
    assign m2 = (x2 - x1) * KB;
endmodule

// File: rtl/wc_winograd_f44.sv
// wc_winograd_f44: pipelined 1-D Winograd F(4,4) correlation tile, 2-cycle latency; WC_SAT_EN selects saturation instead of wrap
module wc_winograd_f44 import wc_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int G0 = G0_DEF,
    parameter int G1 = G1_DEF,
    parameter int G2 = G2_DEF,
    parameter int G3 = G3_DEF
) (
    input logic clk,
    input logic rst,
    wc_winograd_f44_if.slave io
);
    localparam int AW = 2*DW + 4;
    localparam logic signed [AW-1:0] MAXV = AW'((1 << (DW-1)) - 1);
    localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
    logic signed [DW-1:0] d_r [N_IN];
    logic signed [AW-1:0] a [3], b [3], c [3], p [9], p_r [9], o [6], y [N_OUT];
    logic [N_OUT*DW-1:0] z_r;
    function automatic logic [DW-1:0] fit(input logic signed [AW-1:0] v);
`ifdef WC_SAT_EN
        return v > MAXV ? DW'(MAXV) : v < MINV ? DW'(MINV) : DW'(v);
`else
        return DW'(v);
`endif
    endfunction
    // outer input transform on overlapping 3-sample blocks: X0-X1, X1, X2-X1
    for (genvar i = 0; i < 3; i++) begin : g_xf
        assign a[i] = AW'(d_r[i]) - AW'(d_r[i+2]);
        assign b[i] = AW'(d_r[i+2]);
        assign c[i] = AW'(d_r[i+4]) - AW'(d_r[i+2]);
    end
    wc_f22 #(.W(AW), .GA(G0),      .GB(G1))      u_k0 (.x0(a[0]), .x1(a[1]), .x2(a[2]), .m0(p[0]), .m1(p[1]), .m2(p[2]));
    wc_f22 #(.W(AW), .GA(G0 + G2), .GB(G1 + G3)) u_k1 (.x0(b[0]), .x1(b[1]), .x2(b[2]), .m0(p[3]), .m1(p[4]), .m2(p[5]));
    wc_f22 #(.W(AW), .GA(G2),      .GB(G3))      u_k2 (.x0(c[0]), .x1(c[1]), .x2(c[2]), .m0(p[6]), .m1(p[7]), .m2(p[8]));
    // inner output transform per kernel, then outer: Y0 = M1+M2, Y1 = M2+M3
    for (genvar i = 0; i < 3; i++) begin : g_of
        assign o[2*i]   = p_r[3*i] + p_r[3*i+1];
        assign o[2*i+1] = p_r[3*i+1] + p_r[3*i+2];
    end
    assign y[0] = o[0] + o[2];
    assign y[1] = o[1] + o[3];
    assign y[2] = o[2] + o[4];
    assign y[3] = o[3] + o[5];
    assign io.Z = z_r;
    // S0: capture the raw sample tile
    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < N_IN; i++)
            d_r[i] <= rst ? '0 : io.D[(N_IN-i)*DW-1 -: DW];
    end
    // S1: register the nine kernel products
    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < 9; i++)
            p_r[i] <= rst ? '0 : p[i];
    end
    // S2: output transform narrowed to DW bits into Z
    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < N_OUT; i++)
            z_r[(N_OUT-i)*DW-1 -: DW] <= rst ? '0 : fit(y[i]);
    end
endmodule

// File: tb/tb_wc_winograd_f44.sv
// tb_wc_winograd_f44: directed scoreboard bench for the Winograd F(4,4) tile
module tb_wc_winograd_f44;
    logic clk = 0;
    logic rst = 0;
    logic iss = 0;
    logic [2:0] pipe;
    bit fresh = 0;
    int total = 0;
    int bad = 0;
    logic [39:0] q [$];
    logic [39:0] e;
    wc_winograd_f44_if #(.DW(10)) io ();
    wc_winograd_f44 dut (.clk(clk), .rst(rst), .io(io.slave));
    always #5 clk = ~clk;

    function automatic logic [69:0] pk7(input int v [7]);
        logic [69:0] r;
        for (int i = 0; i < 7; i++) r[(6-i)*10 +: 10] = 10'(v[i]);
        return r;
    endfunction

    function automatic logic [39:0] pk4(input int v [4]);
        logic [39:0] r;
        for (int i = 0; i < 4; i++) r[(3-i)*10 +: 10] = 10'(v[i]);
        return r;
    endfunction

    task automatic issue(input logic [69:0] d, input logic [39:0] ex, input bit chk);
        @(negedge clk);
        io.D = d;
        iss = chk;
        if (chk) q.push_back(ex);
    endtask

    // marks which output cycles carry a checked tile (tile sampled at edge n appears after edge n+2)
    always @(posedge clk or posedge rst)
        if (rst) pipe <= '0;
        else pipe <= {pipe[1:0], iss};

    // monitor: pop an expectation whenever a tile emerges; Z must be 0 after reset until then
    always @(negedge clk) begin
        if (pipe[2]) begin
            fresh = 0;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL tile: output present got %h, no expected tile queued", io.Z);
            end else begin
                e = q.pop_front();
                if (io.Z !== e) begin
                    bad++;
                    $display("FAIL tile: got %h want %h", io.Z, e);
                end
            end
        end else if (fresh) begin
            total++;
            if (io.Z !== 40'd0) begin
                bad++;
                $display("FAIL zero_after_reset: got %h want 0", io.Z);
            end
        end
    end

    logic [69:0] d2, d3, dmax, dmin;
    logic [39:0] z2, z3, zmax, zmin;

    initial begin
        d2 = pk7('{2, -10, 3, 4, -13, -18, -16});
        z2 = pk4('{35, -17, -62, -40});
        d3 = pk7('{-19, -6, 3, -9, -12, 11, -4});
        z3 = pk4('{-7, -51, -4, 44});
        dmax = pk7('{511, 511, 511, 511, 511, 511, 511});
        dmin = pk7('{-512, -512, -512, -512, -512, -512, -512});
`ifdef WC_SAT_EN
        zmax = pk4('{511, 511, 511, 511});
`else
        zmax = pk4('{509, 509, 509, 509});
`endif
        zmin = pk4('{-512, -512, -512, -512});
        io.D = '0;
        #1 rst = 1;
        fresh = 1;
        #1;
        total++;
        if (io.Z !== 40'd0) begin bad++; $display("FAIL reset_async: got %h want 0", io.Z); end
        for (int i = 0; i < 4; i++) issue(70'({$urandom, $urandom, $urandom}), '0, 0);
        @(negedge clk);
        rst = 0;
        io.D = '0;
        issue('0, '0, 0);
        issue('0, '0, 0);
        for (int i = 0; i < 6; i++) issue(d2, z2, 1);
        issue(d3, z3, 1);
        issue(dmax, zmax, 1);
        issue(dmin, zmin, 1);
        issue(d2, z2, 1);
        issue(d3, z3, 1);
        for (int i = 0; i < 3; i++) issue('0, '0, 0);
        issue(d2, z2, 1);
        @(posedge clk);
        #2 rst = 1;
        q.delete();
        fresh = 1;
        iss = 0;
        #1;
        total++;
        if (io.Z !== 40'd0) begin bad++; $display("FAIL reset_midstream: got %h want 0", io.Z); end
        @(negedge clk);
        rst = 0;
        io.D = d3;
        iss = 1;
        q.push_back(z3);
        for (int i = 0; i < 4; i++) issue('0, '0, 0);
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL drain: got %0d tiles pending want 0", q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
